// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner.
// Holds the status word field positions and the debounce FSM state type.
package btn_pkg;

    localparam int STATUS_LVL_LSB = 0;
    localparam int STATUS_TGL_LSB = 4;
    localparam int STATUS_CNT_LSB = 8;
    localparam int STATUS_CNT_W   = 8;
    localparam int STATUS_BTN_W   = 4;

    typedef enum logic {
        DB_STABLE,
        DB_SETTLING
    } db_state_t;

    // Number of simultaneous press events in a 4-bit event mask.
    function automatic logic [3:0] popcount4(input logic [3:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button path: two-flop synchroniser, debounce FSM with run counter,
// and a one-cycle rise indication when the accepted level goes to pressed.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic            sync_a;
    logic            sync_b;
    logic            pressed;
    db_state_t       state;
    db_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic            level_q;
    logic            level_next;
    logic            level_d;

    // Synchroniser resets to the released (high) pin level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= btn_n;
            sync_b <= sync_a;
        end
    end

    assign pressed = ~sync_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DB_STABLE;
            cnt     <= '0;
            level_q <= 1'b0;
            level_d <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            level_q <= level_next;
            level_d <= level_q;
        end
    end

    // A sample that agrees with the current level always cancels settling,
    // even on the cycle the count would otherwise have completed.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level_q;
        case (state)
            DB_STABLE: begin
                cnt_next = '0;
                if (pressed != level_q) begin
                    state_next = DB_SETTLING;
                    cnt_next   = CNT_ONE;
                end
            end
            DB_SETTLING: begin
                if (pressed == level_q) begin
                    state_next = DB_STABLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = DB_STABLE;
                    cnt_next   = '0;
                    level_next = pressed;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = DB_STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = level_q & ~level_d;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the active-low board push-buttons and packs clean levels,
// press toggles and a wrapping press counter into a 32-bit status word.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [NUM_BTN-1:0] btn_n,
    input  logic               clr,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [31:0]        status_word
);

    logic [NUM_BTN-1:0]      level;
    logic [NUM_BTN-1:0]      rise;
    logic [STATUS_BTN_W-1:0] level_all;
    logic [STATUS_BTN_W-1:0] rise_all;

    logic [STATUS_BTN_W-1:0] lvl_q;
    logic [STATUS_BTN_W-1:0] tgl_q;
    logic [STATUS_CNT_W-1:0] cnt_q;
    logic [NUM_BTN-1:0]      press_q;

    logic [STATUS_BTN_W-1:0] tgl_next;
    logic [STATUS_CNT_W-1:0] cnt_next;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk_clk),
            .rst_n(reset_reset_n),
            .btn_n(btn_n[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    // Buttons beyond NUM_BTN are tied off so their status bits read zero.
    always_comb begin
        level_all              = '0;
        rise_all               = '0;
        level_all[NUM_BTN-1:0] = level;
        rise_all[NUM_BTN-1:0]  = rise;
    end

    // Clear happens first, so presses on the clear cycle land on a zeroed base.
    always_comb begin
        tgl_next = clr ? '0 : tgl_q;
        cnt_next = clr ? '0 : cnt_q;
        tgl_next = tgl_next ^ rise_all;
        cnt_next = cnt_next + STATUS_CNT_W'(popcount4(rise_all));
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lvl_q   <= '0;
            tgl_q   <= '0;
            cnt_q   <= '0;
            press_q <= '0;
        end else begin
            lvl_q   <= level_all;
            tgl_q   <= tgl_next;
            cnt_q   <= cnt_next;
            press_q <= rise;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_LVL_LSB +: STATUS_BTN_W] = lvl_q;
        status_word[STATUS_TGL_LSB +: STATUS_BTN_W] = tgl_q;
        status_word[STATUS_CNT_LSB +: STATUS_CNT_W] = cnt_q;
    end

    assign press_pulse = press_q;

endmodule
